// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the serial pattern-detector path. The serializer
// and the detector bench both import this package, so the default word
// width and idle level stay in one place.
//
// Contents:
//   ser_state_t   - serializer state (IDLE: no word in flight, SHIFT: sending)
//   SER_WIDTH     - default word length in bits
//   SER_IDLE_BIT  - default level on the serial line between words
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int   SER_WIDTH    = 8;
    localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/word_serializer.sv
// word_serializer
// Parallel-to-serial front end feeding the count01 detector. A WIDTH-bit
// word is accepted through a valid/ready handshake and sent one bit per
// clock on x. Words accepted back to back stream with no idle bubble, so the
// detector sees one continuous bitstream across word boundaries.
//
// Parameters:
//   WIDTH      - word length in bits (2 or more)
//   MSB_FIRST  - 1: din[WIDTH-1] is sent first, 0: din[0] is sent first
//   IDLE_BIT   - level driven on x while no word is being sent
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   din         in   parallel word, sampled only on acceptance
//   din_valid   in   upstream presents a word on din
//   din_ready   out  a word can be accepted this cycle (combinational)
//   x           out  serial data bit (registered)
//   x_valid     out  x carries a real data bit (registered)
//   frame_done  out  one-cycle pulse alongside the last bit of a word
module word_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH     = SER_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic             at_last;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // cnt is the index of the bit currently on x, so the word is finished
    // when it reaches WIDTH-1. This equality is the only terminal test, which
    // keeps non-power-of-two widths from ever running past the last bit.
    assign at_last  = (cnt == LAST_IDX);
    assign cnt_next = cnt + CNT_W'(1);

    // Ready in IDLE, and also while the last bit of the current word is on
    // x so the next word can be loaded without a gap.
    assign din_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && at_last);
    assign accept    = din_valid && din_ready;

    // The first bit of a word goes straight into x when the word is loaded,
    // so shreg only ever holds the bits still waiting to be sent, already
    // positioned so the next one sits at the output end of the register.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign load_bit      = din[WIDTH-1];
            assign load_rest     = {din[WIDTH-2:0], 1'b0};
            assign head_bit      = shreg[WIDTH-1];
            assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign load_bit      = din[0];
            assign load_rest     = {1'b0, din[WIDTH-1:1]};
            assign head_bit      = shreg[0];
            assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    endgenerate

    // Single state/datapath process. Acceptance takes priority, which covers
    // both a fresh word from IDLE and a gapless reload on the last bit. A
    // word that is mid-shift just advances. Anything else (IDLE without a
    // word, or the last bit without a successor) parks the line at IDLE_BIT.
    // Reset discards any partially sent word; it is never resumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            x          <= IDLE_BIT;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else if (accept) begin
            state      <= ST_SHIFT;
            cnt        <= '0;
            shreg      <= load_rest;
            x          <= load_bit;
            x_valid    <= 1'b1;
            frame_done <= 1'b0;
        end else if ((state == ST_SHIFT) && !at_last) begin
            cnt        <= cnt_next;
            shreg      <= shreg_shifted;
            x          <= head_bit;
            x_valid    <= 1'b1;
            frame_done <= (cnt_next == LAST_IDX);
        end else begin
            state      <= ST_IDLE;
            cnt        <= '0;
            x          <= IDLE_BIT;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
// Self-checking bench for word_serializer. Two instances run side by side:
// an 8-bit MSB-first one (the default configuration) and a 5-bit LSB-first
// one. The reference model turns every accepted word into a queue of
// expected serial bits; each cycle the next queued bit is what must be on x,
// and a new word may only be accepted once nothing is left waiting.
module tb_word_serializer;
    import serial_pkg::*;

    typedef struct packed {
        logic v;
        logic b;
        logic last;
    } exp_bit_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] din_a;
    logic       valid_a;
    logic       ready_a, x_a, xv_a, fd_a;

    logic [4:0] din_b;
    logic       valid_b;
    logic       ready_b, x_b, xv_b, fd_b;

    exp_bit_t   q_a[$];
    exp_bit_t   q_b[$];
    exp_bit_t   cur_a;
    exp_bit_t   cur_b;

    int         check_count = 0;
    int         error_count = 0;

    always #5 clk = ~clk;

    word_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1),
        .IDLE_BIT  (1'b0)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_a),
        .din_valid  (valid_a),
        .din_ready  (ready_a),
        .x          (x_a),
        .x_valid    (xv_a),
        .frame_done (fd_a)
    );

    word_serializer #(
        .WIDTH     (5),
        .MSB_FIRST (1'b0),
        .IDLE_BIT  (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_b),
        .din_valid  (valid_b),
        .din_ready  (ready_b),
        .x          (x_b),
        .x_valid    (xv_b),
        .frame_done (fd_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected bit order for the 8-bit MSB-first instance.
    task automatic pushWordA(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            q_a.push_back('{v: 1'b1, b: w[7-i], last: (i == 7)});
        end
    endtask

    // Expected bit order for the 5-bit LSB-first instance.
    task automatic pushWordB(input logic [4:0] w);
        for (int i = 0; i < 5; i++) begin
            q_b.push_back('{v: 1'b1, b: w[i], last: (i == 4)});
        end
    endtask

    // Checks every output of both instances at once; x must sit at the idle
    // level (0) whenever no data bit is expected.
    task automatic checkAll(input string phase);
        checkOutput({phase, "_a_x"},     32'(x_a),     32'(cur_a.v & cur_a.b));
        checkOutput({phase, "_a_xv"},    32'(xv_a),    32'(cur_a.v));
        checkOutput({phase, "_a_fd"},    32'(fd_a),    32'(cur_a.v & cur_a.last));
        checkOutput({phase, "_a_ready"}, 32'(ready_a), 32'(q_a.size() == 0));
        checkOutput({phase, "_b_x"},     32'(x_b),     32'(cur_b.v & cur_b.b));
        checkOutput({phase, "_b_xv"},    32'(xv_b),    32'(cur_b.v));
        checkOutput({phase, "_b_fd"},    32'(fd_b),    32'(cur_b.v & cur_b.last));
        checkOutput({phase, "_b_ready"}, 32'(ready_b), 32'(q_b.size() == 0));
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, record any
    // acceptance in the model, then advance the model past the rising edge.
    task automatic applyStimulus(input string phase,
                                 input logic va, input logic [7:0] da,
                                 input logic vb, input logic [4:0] db,
                                 output logic acc_a, output logic acc_b);
        valid_a = va;
        din_a   = da;
        valid_b = vb;
        din_b   = db;
        @(negedge clk);
        checkAll(phase);
        acc_a = rst_n && va && (q_a.size() == 0);
        acc_b = rst_n && vb && (q_b.size() == 0);
        if (acc_a) pushWordA(da);
        if (acc_b) pushWordB(db);
        @(posedge clk);
        #1;
        cur_a = (q_a.size() != 0) ? q_a.pop_front() : exp_bit_t'('0);
        cur_b = (q_b.size() != 0) ? q_b.pop_front() : exp_bit_t'('0);
    endtask

    task automatic idleCycles(input string phase, input int n);
        logic aa, ab;
        for (int i = 0; i < n; i++) begin
            applyStimulus(phase, 1'b0, $urandom, 1'b0, $urandom, aa, ab);
        end
    endtask

    // Holds din_valid high on instance A and presents w0 until taken, then
    // w1 until taken, so the second word waits on din_ready.
    task automatic sendPairA(input string phase, input logic [7:0] w0, input logic [7:0] w1);
        logic aa, ab;
        int   taken = 0;
        for (int c = 0; c < 40 && taken < 2; c++) begin
            applyStimulus(phase, 1'b1, (taken == 0) ? w0 : w1, 1'b0, 5'd0, aa, ab);
            if (aa) taken++;
        end
        checkOutput({phase, "_accepts"}, 32'(taken), 32'd2);
    endtask

    // Asserts reset between clock edges and checks that outputs clear
    // without waiting for an edge.
    task automatic assertResetMidCycle(input string phase);
        #2;
        rst_n = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        cur_a = '0;
        cur_b = '0;
        checkAll(phase);
    endtask

    logic acc_a, acc_b;

    initial begin
        valid_a = 1'b0;
        valid_b = 1'b0;
        din_a   = '0;
        din_b   = '0;
        cur_a   = '0;
        cur_b   = '0;

        // Reset asserted before any clock edge must clear everything.
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("rst_async");
        // din_valid during reset must not start a word.
        applyStimulus("rst_hold", 1'b1, 8'hFF, 1'b1, 5'h1F, acc_a, acc_b);
        applyStimulus("rst_hold", 1'b0, 8'h00, 1'b0, 5'h00, acc_a, acc_b);
        rst_n = 1'b1;
        idleCycles("idle", 2);

        // Single words: 8'hA5 MSB-first and 5'b10110 LSB-first.
        applyStimulus("single", 1'b1, 8'hA5, 1'b1, 5'b10110, acc_a, acc_b);
        checkOutput("single_a_accept", 32'(acc_a), 32'd1);
        checkOutput("single_b_accept", 32'(acc_b), 32'd1);
        idleCycles("single", 10);

        // Back-to-back streaming with valid held high.
        sendPairA("b2b", 8'h0F, 8'hF0);
        idleCycles("b2b", 10);

        // Stall: FF presented while 00 is shifting is held off until the
        // last bit of 00.
        sendPairA("stall", 8'h00, 8'hFF);
        idleCycles("stall", 10);

        // Reset in the middle of 8'hC3, then a clean 8'h81.
        applyStimulus("midrst", 1'b1, 8'hC3, 1'b0, 5'd0, acc_a, acc_b);
        idleCycles("midrst", 3);
        assertResetMidCycle("midrst_clear");
        idleCycles("midrst_hold", 2);
        rst_n = 1'b1;
        applyStimulus("after_rst", 1'b1, 8'h81, 1'b0, 5'd0, acc_a, acc_b);
        checkOutput("after_rst_accept", 32'(acc_a), 32'd1);
        idleCycles("after_rst", 10);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 3) != 0), 8'($urandom),
                          ($urandom_range(0, 3) != 0), 5'($urandom),
                          acc_a, acc_b);
        end
        idleCycles("drain", 10);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
